// File: rtl/dp_ram_bytewise.sv
// dp_ram_bytewise
// True dual-port RAM on a single clock, with per-byte write enables, an
// optional output register, a selectable same-port read-during-write mode and
// cross-port collision detection.
//
// Ports (x = a | b):
//   clk_i        clock, all logic on the rising edge
//   rst_i        synchronous active-high reset (flushes pipeline; memory kept)
//   en_i_x       request strobe
//   we_i_x       byte write enables (NB lanes); all zero means read
//   addr_i_x     word address
//   data_i_x     write data, lane k = bits [8k+7:8k]
//   data_o_x     read data, holds its last value while valid_o_x = 0
//   valid_o_x    data_o_x carries the result of a request
//   collision_o  one-cycle pulse, aligned with valid_o_x, when both ports hit
//                the same address and at least one of them writes
module dp_ram_bytewise #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned WRITE_MODE = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      en_i_a,
  input  logic [DATA_WIDTH/8-1:0]   we_i_a,
  input  logic [ADDR_WIDTH-1:0]     addr_i_a,
  input  logic [DATA_WIDTH-1:0]     data_i_a,
  output logic [DATA_WIDTH-1:0]     data_o_a,
  output logic                      valid_o_a,
  input  logic                      en_i_b,
  input  logic [DATA_WIDTH/8-1:0]   we_i_b,
  input  logic [ADDR_WIDTH-1:0]     addr_i_b,
  input  logic [DATA_WIDTH-1:0]     data_i_b,
  output logic [DATA_WIDTH-1:0]     data_o_b,
  output logic                      valid_o_b,
  output logic                      collision_o
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] rd_word_a, rd_word_b;
  logic                  collide;

  logic [DATA_WIDTH-1:0] s1_data_a, s1_data_b;
  logic                  s1_valid_a, s1_valid_b, s1_col;

  assign old_a = mem[addr_i_a];
  assign old_b = mem[addr_i_b];

  // Write-first only merges this port's own lanes into the old word; a write
  // from the other port in the same cycle is never forwarded, so a reading
  // port always sees the pre-write word on a cross-port collision.
  always_comb begin
    rd_word_a = old_a;
    rd_word_b = old_b;
    if (WRITE_MODE != 0) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (we_i_a[k]) rd_word_a[8*k +: 8] = data_i_a[8*k +: 8];
        if (we_i_b[k]) rd_word_b[8*k +: 8] = data_i_b[8*k +: 8];
      end
    end
  end

  assign collide = en_i_a && en_i_b && (addr_i_a == addr_i_b)
                   && ((|we_i_a) || (|we_i_b));

  // Port B lanes are assigned first so that a lane enabled by both ports
  // ends up with port A data (last nonblocking assignment wins).
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (en_i_b && we_i_b[k]) mem[addr_i_b][8*k +: 8] <= data_i_b[8*k +: 8];
        if (en_i_a && we_i_a[k]) mem[addr_i_a][8*k +: 8] <= data_i_a[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_data_a  <= '0;
      s1_data_b  <= '0;
      s1_valid_a <= 1'b0;
      s1_valid_b <= 1'b0;
      s1_col     <= 1'b0;
    end else begin
      s1_valid_a <= en_i_a;
      s1_valid_b <= en_i_b;
      s1_col     <= collide;
      if (en_i_a) s1_data_a <= rd_word_a;
      if (en_i_b) s1_data_b <= rd_word_b;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] s2_data_a, s2_data_b;
    logic                  s2_valid_a, s2_valid_b, s2_col;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s2_data_a  <= '0;
        s2_data_b  <= '0;
        s2_valid_a <= 1'b0;
        s2_valid_b <= 1'b0;
        s2_col     <= 1'b0;
      end else begin
        s2_valid_a <= s1_valid_a;
        s2_valid_b <= s1_valid_b;
        s2_col     <= s1_col;
        if (s1_valid_a) s2_data_a <= s1_data_a;
        if (s1_valid_b) s2_data_b <= s1_data_b;
      end
    end

    assign data_o_a    = s2_data_a;
    assign data_o_b    = s2_data_b;
    assign valid_o_a   = s2_valid_a;
    assign valid_o_b   = s2_valid_b;
    assign collision_o = s2_col;
  end else begin : g_no_out_reg
    assign data_o_a    = s1_data_a;
    assign data_o_b    = s1_data_b;
    assign valid_o_a   = s1_valid_a;
    assign valid_o_b   = s1_valid_b;
    assign collision_o = s1_col;
  end

endmodule

// File: tb/tb_dp_ram_bytewise.sv
// Directed testbench for dp_ram_bytewise. Two instances share the same
// stimulus: u_fast (OUT_REG=0, read-first) and u_slow (OUT_REG=1,
// write-first). After each tick, u_fast reflects the request just sampled
// and u_slow the request of the tick before.
module tb_dp_ram_bytewise;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_a, en_b;
  logic [3:0]  we_a, we_b;
  logic [9:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic [31:0] f_dout_a, f_dout_b, s_dout_a, s_dout_b;
  logic        f_vld_a, f_vld_b, f_col, s_vld_a, s_vld_b, s_col;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  dp_ram_bytewise #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .OUT_REG(0), .WRITE_MODE(0)) u_fast (
    .clk_i(clk), .rst_i(rst),
    .en_i_a(en_a), .we_i_a(we_a), .addr_i_a(addr_a), .data_i_a(din_a),
    .data_o_a(f_dout_a), .valid_o_a(f_vld_a),
    .en_i_b(en_b), .we_i_b(we_b), .addr_i_b(addr_b), .data_i_b(din_b),
    .data_o_b(f_dout_b), .valid_o_b(f_vld_b),
    .collision_o(f_col)
  );

  dp_ram_bytewise #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .OUT_REG(1), .WRITE_MODE(1)) u_slow (
    .clk_i(clk), .rst_i(rst),
    .en_i_a(en_a), .we_i_a(we_a), .addr_i_a(addr_a), .data_i_a(din_a),
    .data_o_a(s_dout_a), .valid_o_a(s_vld_a),
    .en_i_b(en_b), .we_i_b(we_b), .addr_i_b(addr_b), .data_i_b(din_b),
    .data_o_b(s_dout_b), .valid_o_b(s_vld_b),
    .collision_o(s_col)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic port_a(input logic en, input logic [3:0] we, input logic [9:0] addr,
                        input logic [31:0] d);
    en_a = en; we_a = we; addr_a = addr; din_a = d;
  endtask

  task automatic port_b(input logic en, input logic [3:0] we, input logic [9:0] addr,
                        input logic [31:0] d);
    en_b = en; we_b = we; addr_b = addr; din_b = d;
  endtask

  task automatic idle();
    port_a(1'b0, 4'h0, 10'd0, 32'h0);
    port_b(1'b0, 4'h0, 10'd0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check("rst f valid_a", {31'd0, f_vld_a}, 32'd0);
    check("rst f valid_b", {31'd0, f_vld_b}, 32'd0);
    check("rst f data_a", f_dout_a, 32'd0);
    check("rst f data_b", f_dout_b, 32'd0);
    check("rst f col", {31'd0, f_col}, 32'd0);
    check("rst s valid_b", {31'd0, s_vld_b}, 32'd0);
    check("rst s data_b", s_dout_b, 32'd0);
    check("rst s col", {31'd0, s_col}, 32'd0);
    rst = 1'b0;

    // preload: addr3=0, addr7=0, addr9=5, addr2=1
    port_a(1'b1, 4'hF, 10'd3, 32'h0);
    port_b(1'b1, 4'hF, 10'd7, 32'h0);
    tick();
    port_a(1'b1, 4'hF, 10'd9, 32'h5);
    port_b(1'b1, 4'hF, 10'd2, 32'h1);
    tick();
    idle();
    tick();
    tick();

    // read-during-write on port A
    port_a(1'b1, 4'hF, 10'd3, 32'hDEADBEEF);
    tick();
    idle();
    check("rdw f data_a", f_dout_a, 32'h0);
    check("rdw f valid_a", {31'd0, f_vld_a}, 32'd1);
    tick();
    check("rdw s data_a", s_dout_a, 32'hDEADBEEF);
    check("rdw s valid_a", {31'd0, s_vld_a}, 32'd1);
    check("hold f valid_a", {31'd0, f_vld_a}, 32'd0);
    check("hold f data_a", f_dout_a, 32'h0);
    tick();

    // byte-lane write and readback
    port_a(1'b1, 4'hF, 10'd5, 32'hAABBCCDD);
    tick();
    port_a(1'b1, 4'b0101, 10'd5, 32'h11223344);
    tick();
    idle();
    port_b(1'b1, 4'h0, 10'd5, 32'h0);
    tick();
    idle();
    check("lane f data_b", f_dout_b, 32'hAA22CC44);
    check("lane f valid_b", {31'd0, f_vld_b}, 32'd1);
    tick();
    check("lane s data_b", s_dout_b, 32'hAA22CC44);
    check("lane s valid_b", {31'd0, s_vld_b}, 32'd1);
    tick();

    // write/write collision on addr 7
    port_a(1'b1, 4'b0011, 10'd7, 32'h11111111);
    port_b(1'b1, 4'b0110, 10'd7, 32'h22222222);
    tick();
    idle();
    check("ww f col", {31'd0, f_col}, 32'd1);
    check("ww f valid_a", {31'd0, f_vld_a}, 32'd1);
    check("ww f valid_b", {31'd0, f_vld_b}, 32'd1);
    check("ww s col early", {31'd0, s_col}, 32'd0);
    tick();
    check("ww f col pulse", {31'd0, f_col}, 32'd0);
    check("ww s col", {31'd0, s_col}, 32'd1);
    check("ww s valid_b", {31'd0, s_vld_b}, 32'd1);
    tick();
    check("ww s col pulse", {31'd0, s_col}, 32'd0);
    port_b(1'b1, 4'h0, 10'd7, 32'h0);
    tick();
    idle();
    check("ww f read", f_dout_b, 32'h00221111);
    tick();
    check("ww s read", s_dout_b, 32'h00221111);
    tick();

    // cross-port read/write on addr 9 (holds 5)
    port_a(1'b1, 4'hF, 10'd9, 32'h9);
    port_b(1'b1, 4'h0, 10'd9, 32'h0);
    tick();
    port_a(1'b0, 4'h0, 10'd0, 32'h0);
    check("xrw f data_b", f_dout_b, 32'h5);
    check("xrw f col", {31'd0, f_col}, 32'd1);
    tick();
    idle();
    check("xrw s data_b", s_dout_b, 32'h5);
    check("xrw s col", {31'd0, s_col}, 32'd1);
    check("xrw f next", f_dout_b, 32'h9);
    check("xrw f no col", {31'd0, f_col}, 32'd0);
    tick();
    check("xrw s next", s_dout_b, 32'h9);
    check("xrw s no col", {31'd0, s_col}, 32'd0);
    tick();

    // reset mid-operation
    port_b(1'b1, 4'h0, 10'd5, 32'h0);
    tick();
    rst = 1'b1;
    port_a(1'b1, 4'hF, 10'd2, 32'hFFFFFFFF);
    tick();
    rst = 1'b0;
    idle();
    check("mrst f valid_b", {31'd0, f_vld_b}, 32'd0);
    check("mrst f data_b", f_dout_b, 32'd0);
    check("mrst f col", {31'd0, f_col}, 32'd0);
    check("mrst s valid_b", {31'd0, s_vld_b}, 32'd0);
    check("mrst s data_b", s_dout_b, 32'd0);
    check("mrst s col", {31'd0, s_col}, 32'd0);
    tick();
    check("mrst s flushed", {31'd0, s_vld_b}, 32'd0);
    port_b(1'b1, 4'h0, 10'd2, 32'h0);
    tick();
    idle();
    check("mrst f read2", f_dout_b, 32'h1);
    tick();
    check("mrst s read2", s_dout_b, 32'h1);
    tick();

    // streaming reads of addrs 0..15 after preload value=addr
    for (int i = 0; i < 16; i++) begin
      port_a(1'b1, 4'hF, 10'(i), 32'(i));
      tick();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      port_b(1'b1, 4'h0, 10'(i), 32'h0);
      tick();
      check($sformatf("strm f valid %0d", i), {31'd0, f_vld_b}, 32'd1);
      check($sformatf("strm f data %0d", i), f_dout_b, 32'(i));
      if (i > 0) begin
        check($sformatf("strm s valid %0d", i - 1), {31'd0, s_vld_b}, 32'd1);
        check($sformatf("strm s data %0d", i - 1), s_dout_b, 32'(i - 1));
      end
    end
    idle();
    tick();
    check("strm s valid 15", {31'd0, s_vld_b}, 32'd1);
    check("strm s data 15", s_dout_b, 32'd15);
    check("strm f end valid", {31'd0, f_vld_b}, 32'd0);
    check("strm f end hold", f_dout_b, 32'd15);
    tick();
    check("strm s end valid", {31'd0, s_vld_b}, 32'd0);
    check("strm s end hold", s_dout_b, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
